// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide unit for the execute stage.
// Shift-add multiply (or single-cycle when FAST_MUL) and restoring divide.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] rh;
  logic [WIDTH-1:0] rl;
  logic [CW-1:0]    cnt;
  logic             neg_hi;
  logic             neg_lo;

  logic             is_div;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             dbz_in;
  logic             fast_in;
  logic [2*WIDTH-1:0] fprod;

  assign is_div  = op_i[1];
  assign sgn     = ~op_i[0];
  assign a_neg   = sgn & opa_i[WIDTH-1];
  assign b_neg   = sgn & opb_i[WIDTH-1];
  assign a_mag   = a_neg ? -opa_i : opa_i;
  assign b_mag   = b_neg ? -opb_i : opb_i;
  assign accept  = start_i & ~annul_i & (state == IDLE);
  assign dbz_in  = is_div & (opb_i == '0);
  assign fast_in = FAST_MUL & ~is_div;

  always_comb begin
    fprod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    if (a_neg ^ b_neg)
      fprod = -fprod;
  end

  // Datapath step: rh/rl hold the running product or remainder/quotient.
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dsh;
  logic             dge;
  logic [WIDTH-1:0] ddif;
  logic [WIDTH-1:0] nh;
  logic [WIDTH-1:0] nl;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  always_comb begin
    msum = {1'b0, rh} + {1'b0, (rl[0] ? m_r : '0)};
    dsh  = {rh, rl[WIDTH-1]};
    dge  = dsh >= {1'b0, m_r};
    ddif = dsh[WIDTH-1:0] - m_r;
    if (op_r[1]) begin
      nh = dge ? ddif : dsh[WIDTH-1:0];
      nl = {rl[WIDTH-2:0], dge};
    end else begin
      nh = msum[WIDTH:1];
      nl = {msum[0], rl[WIDTH-1:1]};
    end
    prod = neg_lo ? -{nh, nl} : {nh, nl};
    if (op_r[1]) begin
      fin_hi = neg_hi ? -nh : nh;
      fin_lo = neg_lo ? -nl : nl;
    end else begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_r          <= '0;
      m_r           <= '0;
      rh            <= '0;
      rl            <= '0;
      cnt           <= '0;
      neg_hi        <= 1'b0;
      neg_lo        <= 1'b0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
    end else begin
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r   <= op_i;
            cnt    <= '0;
            rh     <= '0;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            if (dbz_in) begin
              hi_o          <= opa_i;
              lo_o          <= '1;
              ready_o       <= 1'b1;
              div_by_zero_o <= 1'b1;
              state         <= DONE;
            end else if (fast_in) begin
              {hi_o, lo_o} <= fprod;
              ready_o      <= 1'b1;
              state        <= DONE;
            end else begin
              m_r   <= is_div ? b_mag : a_mag;
              rl    <= is_div ? a_mag : b_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            rh  <= nh;
            rl  <= nl;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              hi_o    <= fin_hi;
              lo_o    <= fin_lo;
              ready_o <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state == CALC) | (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: iterative 32-bit, fast-multiply 32-bit
// and an 8-bit instance swept against a reference model.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op = 2'd0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        annul = 1'b0;
  logic        nil = 1'b0;
  logic [2:0]  start = 3'b000;

  logic        busy0, ready0, dbz0;
  logic [31:0] hi0, lo0;
  logic        busy1, ready1, dbz1;
  logic [31:0] hi1, lo1;
  logic        busy2, ready2, dbz2;
  logic [7:0]  hi2, lo2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .start_i(start[0]), .op_i(op),
    .opa_i(opa), .opb_i(opb), .annul_i(annul),
    .busy_o(busy0), .ready_o(ready0), .div_by_zero_o(dbz0),
    .hi_o(hi0), .lo_o(lo0)
  );

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start_i(start[1]), .op_i(op),
    .opa_i(opa), .opb_i(opb), .annul_i(nil),
    .busy_o(busy1), .ready_o(ready1), .div_by_zero_o(dbz1),
    .hi_o(hi1), .lo_o(lo1)
  );

  muldiv_unit #(.WIDTH(8), .FAST_MUL(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start_i(start[2]), .op_i(op),
    .opa_i(opa[7:0]), .opb_i(opb[7:0]), .annul_i(nil),
    .busy_o(busy2), .ready_o(ready2), .div_by_zero_o(dbz2),
    .hi_o(hi2), .lo_o(lo2)
  );

  task automatic score(input int d, input logic [31:0] h,
                       input logic [31:0] l, input logic z);
    exp_t e;
    int   n;
    checks++;
    case (d)
      0: n = q0.size();
      1: n = q1.size();
      default: n = q2.size();
    endcase
    if (n == 0) begin
      errors++;
      $display("FAIL dut%0d unexpected ready at cycle %0d hi=%h lo=%h", d, cyc, h, l);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      if (h !== e.hi || l !== e.lo || z !== e.dbz || cyc != e.cyc) begin
        errors++;
        $display("FAIL dut%0d result: got hi=%h lo=%h dbz=%b cyc=%0d, want hi=%h lo=%h dbz=%b cyc=%0d",
                 d, h, l, z, cyc, e.hi, e.lo, e.dbz, e.cyc);
      end
    end
  endtask

  task automatic stray(input int d, input logic r, input logic z);
    if (z && !r) begin
      checks++;
      errors++;
      $display("FAIL dut%0d div_by_zero without ready at cycle %0d", d, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ready0) score(0, hi0, lo0, dbz0);
      if (ready1) score(1, hi1, lo1, dbz1);
      if (ready2) score(2, {24'd0, hi2}, {24'd0, lo2}, dbz2);
      stray(0, ready0, dbz0);
      stray(1, ready1, dbz1);
      stray(2, ready2, dbz2);
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] got,
                           input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic issue(input int d, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el, input logic ez, input int lat);
    exp_t e;
    @(negedge clk);
    op = o; opa = a; opb = b;
    start[d] = 1'b1;
    e.hi = eh; e.lo = el; e.dbz = ez; e.cyc = cyc + lat;
    case (d)
      0: begin q0.push_back(e); last_hi = eh; last_lo = el; end
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    start[d] = 1'b0;
    repeat (lat) @(negedge clk);
  endtask

  task automatic model8(input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, output logic [31:0] h,
                        output logic [31:0] l, output logic z, output int lat);
    byte sa, sb;
    int  p, qv, rv;
    sa = a; sb = b;
    z = 1'b0; lat = 9;
    case (o)
      2'd0: p = int'(sa) * int'(sb);
      2'd1: p = int'(a) * int'(b);
      default: p = 0;
    endcase
    h = {24'd0, p[15:8]};
    l = {24'd0, p[7:0]};
    if (o[1]) begin
      if (b == 8'd0) begin
        z = 1'b1; lat = 1;
        h = {24'd0, a}; l = 32'hFF;
      end else begin
        if (o[0]) begin
          qv = int'(a) / int'(b);
          rv = int'(a) % int'(b);
        end else begin
          qv = int'(sa) / int'(sb);
          rv = int'(sa) % int'(sb);
        end
        h = {24'd0, rv[7:0]};
        l = {24'd0, qv[7:0]};
      end
    end
  endtask

  initial begin
    logic [31:0] eh, el;
    logic        ez;
    int          lat;
    logic [1:0]  ro;
    logic [7:0]  ra, rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("reset busy", {31'd0, busy0}, 32'd0);
    expect_eq("reset ready", {31'd0, ready0}, 32'd0);
    expect_eq("reset dbz", {31'd0, dbz0}, 32'd0);
    expect_eq("reset hi", hi0, 32'd0);
    expect_eq("reset lo", lo0, 32'd0);

    issue(0, 2'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    issue(1, 2'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1);
    issue(1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 1);
    issue(1, 2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    issue(0, 2'd1, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 1'b0, 33);
    issue(0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 33);
    issue(0, 2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
    issue(0, 2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    issue(0, 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    issue(0, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
    issue(0, 2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33);
    issue(0, 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);

    // annul mid-calculation, then restart in the first idle cycle
    @(negedge clk);
    op = 2'd3; opa = 32'd100; opb = 32'd7; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    expect_eq("annul busy", {31'd0, busy0}, 32'd0);
    expect_eq("annul ready", {31'd0, ready0}, 32'd0);
    expect_eq("annul hi kept", hi0, last_hi);
    expect_eq("annul lo kept", lo0, last_lo);
    op = 2'd1; opa = 32'd12345; opb = 32'd1000; start[0] = 1'b1;
    q0.push_back('{32'd0, 32'd12345000, 1'b0, cyc + 33});
    last_hi = 32'd0; last_lo = 32'd12345000;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (33) @(negedge clk);

    // start held high with changing operands: only the first is taken
    @(negedge clk);
    op = 2'd3; opa = 32'd100; opb = 32'd7; start[0] = 1'b1;
    q0.push_back('{32'd2, 32'd14, 1'b0, cyc + 33});
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3));
      opa = $urandom;
      opb = $urandom;
    end
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a calculation
    @(negedge clk);
    op = 2'd3; opa = 32'd100; opb = 32'd7; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_eq("midreset busy", {31'd0, busy0}, 32'd0);
    expect_eq("midreset ready", {31'd0, ready0}, 32'd0);
    expect_eq("midreset dbz", {31'd0, dbz0}, 32'd0);
    expect_eq("midreset hi", hi0, 32'd0);
    expect_eq("midreset lo", lo0, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // 8-bit sweep: corners then pseudo-random operands
    model8(2'd2, 8'h80, 8'hFF, eh, el, ez, lat);
    issue(2, 2'd2, 32'h80, 32'hFF, eh, el, ez, lat);
    issue(2, 2'd0, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 9);
    issue(2, 2'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, 9);
    issue(2, 2'd2, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, 9);
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 255));
      rb = (i % 6 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      model8(ro, ra, rb, eh, el, ez, lat);
      issue(2, ro, {24'd0, ra}, {24'd0, rb}, eh, el, ez, lat);
    end

    repeat (5) @(negedge clk);
    if (q0.size() + q1.size() + q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing ready: %0d/%0d/%0d results never arrived",
               q0.size(), q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
